dmem_sized_ctrl: RTL
====================

Name: dmem_sized_ctrl

Overview:
Parametrised data-memory controller, successor to the fixed 128-byte word-only data memory in the MEM stage. Adds byte/half/word loads and stores with sign/zero extension, a req/ready/ack handshake with configurable access latency, and error reporting for misaligned or out-of-range accesses. Little-endian byte array.

Parameters:
ADDR_W, 32, width of addr_i
DEPTH_BYTES, 128, memory size in bytes; must be a multiple of 4 and at least 4
LATENCY, 2, clock edges from request acceptance to ack_o; must be at least 1

Ports:
clk_i  in  1  clock; all logic on the rising edge
rst_i  in  1  synchronous, active-high reset
req_i  in  1  request valid
we_i  in  1  1 = store, 0 = load
size_i  in  2  00 = byte, 01 = half, 10 = word, 11 = reserved
unsigned_i  in  1  loads only: 1 = zero-extend, 0 = sign-extend
addr_i  in  ADDR_W  byte address
data_i  in  32  store data; the low bytes are used for byte and half stores
ready_o  out  1  controller can accept a request
ack_o  out  1  one-cycle completion pulse
data_o  out  32  load result; valid while ack_o is high and held until the next ack
err_o  out  1  qualifies ack_o: the access was rejected

Behaviour:
- Interface: one clock, clk_i. Reset is synchronous and active-high on rst_i.
- Reset values: FSM in IDLE, ready_o=1, ack_o=0, err_o=0, data_o=0, counter=0.
- Memory contents are zeroed at time 0 only. rst_i does not clear them.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: ready_o=1. If req_i is high at an edge, capture we, size, unsigned, addr and data, load the counter with LATENCY-1, and go to WAIT.
  - WAIT: ready_o=0. When the counter is 0, go to RESP at the next edge; otherwise decrement the counter.
  - RESP: ack_o=1 for exactly one cycle, then return to IDLE.
- Timing: ack_o is high in the cycle after the LATENCY-th edge following the accepting edge. Maximum throughput is one request per LATENCY+2 cycles.
- req_i is ignored outside IDLE. Requests are not queued.
- Error conditions are evaluated on the captured request:
  - size=11
  - half access with addr[0]=1
  - word access with addr[1:0]≠0
  - addr + bytes - 1 ≥ DEPTH_BYTES, evaluated at full ADDR_W width with no wrap-around
- On error: no write is performed, data_o=0, err_o=1 during RESP. Otherwise err_o=0.
- Stores: bytes are committed on the edge entering RESP. The value at addr gets data[7:0], addr+1 gets data[15:8], and so on. data_o is left unchanged for stores.
- Loads: data_o is registered on the edge entering RESP, sign- or zero-extended from 8 or 16 bits as selected.
- rst_i asserted in WAIT or RESP aborts the access: no write is committed and no ack_o is produced.
- err_o and data_o hold their values after RESP until the next RESP.

Optional Feature:
DMEM_ACCESS_CNT_EN
- Defined: adds output ports rd_cnt_o[31:0] and wr_cnt_o[31:0].
  - They count successful (err_o=0) loads and stores.
  - They increment on the edge entering RESP, are cleared by rst_i, and wrap modulo 2^32.
- Undefined: the ports and counters are absent. All other behaviour is identical.

Test Plan:
- Reset, then word store 0xDEADBEEF to addr 0x10, then word load from 0x10 (LATENCY=2) -> ack_o high exactly 2 edges after each accepting edge; load returns data_o=0xDEADBEEF, err_o=0.
- Byte loads from 0x13, signed and then unsigned -> 0xFFFFFFDE, then 0x000000DE. Half load from 0x10, signed -> 0xFFFFBEEF.
- Byte store 0x5A to 0x11, then word load from 0x10 -> 0xDEAD5AEF.
- Word load from 0x12, half load from 0x11, size=11, and word access at 0x7E / 0x80 with DEPTH_BYTES=128 -> each gives ack_o with err_o=1 and data_o=0; memory is unchanged on a subsequent word load from 0x10.
- rst_i asserted in the WAIT cycle of a word store 0x12345678 to 0x20 -> no ack_o, ready_o=1 the next cycle, and a load from 0x20 returns 0x00000000.
- req_i held high continuously with LATENCY=1 -> accepts occur every 3 cycles. With DMEM_ACCESS_CNT_EN defined, the counters match the number of non-error acks.

Source files
------------

// File: rtl/dmem_sized_ctrl.sv
// Byte-addressed little-endian data memory with sized loads/stores, req/ready/ack
// handshake and fixed access latency. Define DMEM_ACCESS_CNT_EN for load/store counters.
module dmem_sized_ctrl #(
    parameter int ADDR_W      = 32,
    parameter int DEPTH_BYTES = 128,
    parameter int LATENCY     = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [1:0]        size_i,
    input  logic              unsigned_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       data_i,
    output logic              ready_o,
    output logic              ack_o,
    output logic [31:0]       data_o,
    output logic              err_o
`ifdef DMEM_ACCESS_CNT_EN
    ,
    output logic [31:0]       rd_cnt_o,
    output logic [31:0]       wr_cnt_o
`endif
);

    localparam int IW = $clog2(DEPTH_BYTES);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t              state_r;
    logic [CW-1:0]       cnt_r;
    logic                we_r;
    logic [1:0]          size_r;
    logic                uns_r;
    logic [ADDR_W-1:0]   addr_r;
    logic [31:0]         wdata_r;

    logic [7:0]          mem_r [DEPTH_BYTES] = '{default: 8'h00};

    logic [2:0]          bytes_s;
    logic [ADDR_W:0]     last_s;
    logic                err_s;
    logic                commit_s;
    logic [IW:0]         pos_s [4];
    logic [IW-1:0]       ix_s  [4];
    logic [31:0]         raw_s;

    function automatic logic [31:0] load_ext(input logic [31:0] raw,
                                             input logic [1:0]  size,
                                             input logic        uns);
        logic [31:0] res;
        case (size)
            2'b00:   res = uns ? {24'h000000, raw[7:0]} : {{24{raw[7]}}, raw[7:0]};
            2'b01:   res = uns ? {16'h0000, raw[15:0]}  : {{16{raw[15]}}, raw[15:0]};
            default: res = raw;
        endcase
        return res;
    endfunction

    // Access checks and the (up to) four byte lanes addressed by the captured request
    always_comb begin
        case (size_r)
            2'b00:   bytes_s = 3'd1;
            2'b01:   bytes_s = 3'd2;
            default: bytes_s = 3'd4;
        endcase
        // One extra bit keeps the end-address check free of wrap-around
        last_s = {1'b0, addr_r} + (ADDR_W+1)'(bytes_s) - (ADDR_W+1)'(1);
        err_s  = (size_r == 2'b11)
               | ((size_r == 2'b01) & addr_r[0])
               | ((size_r == 2'b10) & (addr_r[1:0] != 2'b00))
               | (last_s >= (ADDR_W+1)'(DEPTH_BYTES));
        commit_s = (state_r == S_WAIT) && (cnt_r == {CW{1'b0}});
        raw_s = 32'h0000_0000;
        for (int k = 0; k < 4; k++) begin
            pos_s[k] = {1'b0, addr_r[IW-1:0]} + (IW+1)'(k);
            ix_s[k]  = pos_s[k][IW-1:0];
            if (pos_s[k] < (IW+1)'(DEPTH_BYTES)) begin
                raw_s[8*k +: 8] = mem_r[ix_s[k]];
            end else begin
                raw_s[8*k +: 8] = 8'h00;
            end
        end
    end

    // Byte-lane store commit on the edge entering RESP; reset aborts the write
    always_ff @(posedge clk_i) begin
        if (!rst_i && commit_s && we_r && !err_s) begin
            for (int k = 0; k < 4; k++) begin
                if (3'(k) < bytes_s) begin
                    mem_r[ix_s[k]] <= wdata_r[8*k +: 8];
                end
            end
        end
    end

    // Handshake FSM with registered ready/ack/err/data outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= S_IDLE;
            cnt_r   <= {CW{1'b0}};
            we_r    <= 1'b0;
            size_r  <= 2'b00;
            uns_r   <= 1'b0;
            addr_r  <= {ADDR_W{1'b0}};
            wdata_r <= 32'h0000_0000;
            ready_o <= 1'b1;
            ack_o   <= 1'b0;
            err_o   <= 1'b0;
            data_o  <= 32'h0000_0000;
        end else begin
            case (state_r)
                S_IDLE: begin
                    ack_o <= 1'b0;
                    if (req_i) begin
                        we_r    <= we_i;
                        size_r  <= size_i;
                        uns_r   <= unsigned_i;
                        addr_r  <= addr_i;
                        wdata_r <= data_i;
                        cnt_r   <= CW'(LATENCY - 1);
                        ready_o <= 1'b0;
                        state_r <= S_WAIT;
                    end else begin
                        ready_o <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (cnt_r == {CW{1'b0}}) begin
                        state_r <= S_RESP;
                        ack_o   <= 1'b1;
                        err_o   <= err_s;
                        if (err_s) begin
                            data_o <= 32'h0000_0000;
                        end else if (!we_r) begin
                            data_o <= load_ext(raw_s, size_r, uns_r);
                        end
                    end else begin
                        cnt_r <= cnt_r - CW'(1);
                    end
                end
                S_RESP: begin
                    ack_o   <= 1'b0;
                    ready_o <= 1'b1;
                    state_r <= S_IDLE;
                end
                default: begin
                    ack_o   <= 1'b0;
                    ready_o <= 1'b1;
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

`ifdef DMEM_ACCESS_CNT_EN
    // Successful access counters, bumped alongside the RESP entry
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_cnt_o <= 32'h0000_0000;
            wr_cnt_o <= 32'h0000_0000;
        end else if (commit_s && !err_s) begin
            if (we_r) begin
                wr_cnt_o <= wr_cnt_o + 32'd1;
            end else begin
                rd_cnt_o <= rd_cnt_o + 32'd1;
            end
        end
    end
`endif

endmodule
